// File: rtl/pixel_packer_if.sv
// rtl/pixel_packer_if.sv - pixel stream, control and memory write-port bundle for pixel_packer
//
// Purpose: groups the pixel handshake, flush/done control, oob flag and the
//   image-memory write port into one interface.
// Ports (signals):
//   in_valid/in_ready  pixel handshake; x, y, pixel carry the offered pixel
//   flush / done       end-of-frame commit request and its completion pulse
//   oob                sticky out-of-range flag
//   wraddress/data/wren  memory write port
//   clear / clear_busy frame clear request and busy flag (PIXEL_PACKER_CLEAR_EN only)
// Modports: master = pixel source / host, slave = pixel_packer.
interface pixel_packer_if #(
  parameter int ADDR_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [9:0]        x;
  logic [9:0]        y;
  logic              pixel;
  logic              flush;
  logic              done;
  logic              oob;
  logic [ADDR_W-1:0] wraddress;
  logic [7:0]        data;
  logic              wren;
`ifdef PIXEL_PACKER_CLEAR_EN
  logic              clear;
  logic              clear_busy;
`endif

  modport master (
    output in_valid, x, y, pixel, flush,
`ifdef PIXEL_PACKER_CLEAR_EN
    output clear,
    input  clear_busy,
`endif
    input  in_ready, done, oob, wraddress, data, wren
  );

  modport slave (
    input  in_valid, x, y, pixel, flush,
`ifdef PIXEL_PACKER_CLEAR_EN
    input  clear,
    output clear_busy,
`endif
    output in_ready, done, oob, wraddress, data, wren
  );
endinterface

// File: rtl/pixel_packer.sv
// rtl/pixel_packer.sv - packs a 1-bpp pixel stream into bytes of the dual-port image memory
//
// Purpose: accumulates binary pixels (x, y, pixel) into bytes at
//   address = y*BYTES_PER_ROW + x/8, bit x%8, and issues at most one memory write
//   per byte (overwrite, no read-modify-write).
// Ports:
//   clk, reset    clock, synchronous active-high reset
//   bus (slave)   pixel handshake, flush/done, oob, memory write port
// Optional feature: define PIXEL_PACKER_CLEAR_EN to add the clear input and
//   clear_busy output, which zero the whole frame one byte per cycle.
module pixel_packer #(
  parameter int WIDTH         = 640,
  parameter int HEIGHT        = 480,
  parameter int BYTES_PER_ROW = WIDTH / 8,
  parameter int ADDR_W        = 16
) (
  input  logic         clk,
  input  logic         reset,
  pixel_packer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_STREAM = 3'd1,
    S_DRAIN  = 3'd2,
`ifdef PIXEL_PACKER_CLEAR_EN
    S_CLEAR  = 3'd4,
`endif
    S_FLUSH  = 3'd3
  } state_t;

  localparam logic [9:0]  WIDTH_L  = 10'(WIDTH);
  localparam logic [9:0]  HEIGHT_L = 10'(HEIGHT);
  localparam logic [16:0] STRIDE   = 17'(BYTES_PER_ROW);
`ifdef PIXEL_PACKER_CLEAR_EN
  localparam logic [16:0] LAST_ADDR = 17'(BYTES_PER_ROW * HEIGHT - 1);
`endif

  state_t            state_q, state_d;
  logic [16:0]       acc_addr_q, acc_addr_d;
  logic [7:0]        acc_data_q, acc_data_d;
  logic              acc_live_q, acc_live_d;
  logic              flush_pend_q, flush_pend_d;
  logic              wren_q, wren_d;
  logic [ADDR_W-1:0] wraddress_q, wraddress_d;
  logic [7:0]        data_q, data_d;
  logic              done_q, done_d;
  logic              oob_q, oob_d;
`ifdef PIXEL_PACKER_CLEAR_EN
  logic [16:0]       clr_addr_q, clr_addr_d;
  logic              clear_busy_q, clear_busy_d;
`endif

  logic        run, in_ready, accept, in_range, pix_ok, pix_oob, same, flush_now;
  logic        old_c, new_c;
  logic [16:0] pix_addr;
  logic [2:0]  pix_bit;
  logic [16:0] m_addr;
  logic [7:0]  m_data;
  logic        m_live;

  assign run       = (state_q == S_IDLE) || (state_q == S_STREAM);
  assign in_ready  = run && !reset;
  assign accept    = bus.in_valid && in_ready;
  assign in_range  = (bus.x < WIDTH_L) && (bus.y < HEIGHT_L);
  assign pix_ok    = accept && in_range;
  assign pix_oob   = accept && !in_range;
  assign pix_addr  = 17'(bus.y) * STRIDE + 17'(bus.x[9:3]);
  assign pix_bit   = bus.x[2:0];
  assign same      = acc_live_q && (pix_addr == acc_addr_q);
  assign flush_now = run && bus.flush;

  // Accumulator as it stands after merging this cycle's pixel.
  always_comb begin
    m_addr = acc_addr_q;
    m_data = acc_data_q;
    m_live = acc_live_q;
    if (pix_ok) begin
      m_addr = pix_addr;
      if (!same) m_data = 8'h00;
      m_data[pix_bit] = bus.pixel;
      m_live = 1'b1;
    end
  end

  // old_c: the previous byte is displaced; new_c: the merged byte must go out now.
  // Both at once is the double commit that needs S_DRAIN.
  assign old_c = pix_ok && acc_live_q && !same;
  assign new_c = m_live && ((pix_ok && pix_bit == 3'd7) || flush_now);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      acc_addr_q   <= '0;
      acc_data_q   <= '0;
      acc_live_q   <= 1'b0;
      flush_pend_q <= 1'b0;
      wren_q       <= 1'b0;
      wraddress_q  <= '0;
      data_q       <= '0;
      done_q       <= 1'b0;
      oob_q        <= 1'b0;
`ifdef PIXEL_PACKER_CLEAR_EN
      clr_addr_q   <= '0;
      clear_busy_q <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      acc_addr_q   <= acc_addr_d;
      acc_data_q   <= acc_data_d;
      acc_live_q   <= acc_live_d;
      flush_pend_q <= flush_pend_d;
      wren_q       <= wren_d;
      wraddress_q  <= wraddress_d;
      data_q       <= data_d;
      done_q       <= done_d;
      oob_q        <= oob_d;
`ifdef PIXEL_PACKER_CLEAR_EN
      clr_addr_q   <= clr_addr_d;
      clear_busy_q <= clear_busy_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_STREAM: begin
        if (flush_now) begin
          if (old_c && new_c)     state_d = S_DRAIN;
          else if (old_c || new_c) state_d = S_FLUSH;
          else                    state_d = S_IDLE;
        end else if (old_c && new_c) begin
          state_d = S_DRAIN;
        end else if (accept) begin
          state_d = S_STREAM;
        end
      end
      S_DRAIN: state_d = (flush_pend_q || bus.flush) ? S_FLUSH : S_STREAM;
      S_FLUSH: state_d = S_IDLE;
`ifdef PIXEL_PACKER_CLEAR_EN
      S_CLEAR: if (clr_addr_q == LAST_ADDR) state_d = S_FLUSH;
`endif
      default: state_d = S_IDLE;
    endcase
`ifdef PIXEL_PACKER_CLEAR_EN
    if (bus.clear) state_d = S_CLEAR;
`endif
  end

  always_comb begin
    acc_addr_d   = acc_addr_q;
    acc_data_d   = acc_data_q;
    acc_live_d   = acc_live_q;
    flush_pend_d = flush_pend_q;
    wren_d       = 1'b0;
    wraddress_d  = wraddress_q;
    data_d       = data_q;
    done_d       = 1'b0;
    oob_d        = oob_q | pix_oob;
`ifdef PIXEL_PACKER_CLEAR_EN
    clr_addr_d   = clr_addr_q;
    clear_busy_d = clear_busy_q;
`endif
    case (state_q)
      S_IDLE, S_STREAM: begin
        acc_addr_d = m_addr;
        acc_data_d = m_data;
        acc_live_d = m_live;
        if (old_c) begin
          wren_d      = 1'b1;
          wraddress_d = acc_addr_q[ADDR_W-1:0];
          data_d      = acc_data_q;
          // A second commit stays in the accumulator for S_DRAIN.
          if (new_c) flush_pend_d = flush_now;
        end else if (new_c) begin
          wren_d      = 1'b1;
          wraddress_d = m_addr[ADDR_W-1:0];
          data_d      = m_data;
          acc_live_d  = 1'b0;
        end
        if (flush_now && !old_c && !new_c) done_d = 1'b1;
      end
      S_DRAIN: begin
        wren_d       = 1'b1;
        wraddress_d  = acc_addr_q[ADDR_W-1:0];
        data_d       = acc_data_q;
        acc_live_d   = 1'b0;
        flush_pend_d = 1'b0;
      end
      S_FLUSH: begin
        // The final write is on the port this cycle; done follows it.
        done_d = 1'b1;
`ifdef PIXEL_PACKER_CLEAR_EN
        clear_busy_d = 1'b0;
`endif
      end
`ifdef PIXEL_PACKER_CLEAR_EN
      S_CLEAR: begin
        wren_d      = 1'b1;
        wraddress_d = clr_addr_q[ADDR_W-1:0];
        data_d      = 8'h00;
        clr_addr_d  = clr_addr_q + 17'd1;
      end
`endif
      default: ;
    endcase
`ifdef PIXEL_PACKER_CLEAR_EN
    if (bus.clear) begin
      acc_live_d   = 1'b0;
      flush_pend_d = 1'b0;
      wren_d       = 1'b0;
      done_d       = 1'b0;
      clr_addr_d   = '0;
      clear_busy_d = 1'b1;
    end
`endif
  end

  assign bus.in_ready  = in_ready;
  assign bus.wren      = wren_q;
  assign bus.wraddress = wraddress_q;
  assign bus.data      = data_q;
  assign bus.done      = done_q;
  assign bus.oob       = oob_q;
`ifdef PIXEL_PACKER_CLEAR_EN
  assign bus.clear_busy = clear_busy_q;
`endif

endmodule
